// File: rtl/time_pkg.sv
// rtl/time_pkg.sv - shared constants and state encoding for the time-setting block
package time_pkg;

    localparam int PAIR_W = 8;

    localparam logic [7:0] MIN_SEC_MAX = 8'h59;
    localparam logic [7:0] HOUR24_MAX  = 8'h23;
    localparam logic [7:0] HOUR12_MAX  = 8'h12;
    localparam logic [7:0] HOUR12_MIN  = 8'h01;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EDIT = 1'b1
    } adj_state_t;

endpackage

// File: rtl/btn_repeat.sv
// rtl/btn_repeat.sv - rising-edge step pulse with hold-to-repeat for one button
module btn_repeat #(
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    input  logic inhibit,
    output logic rise,
    output logic step,
    output logic held
);

    localparam int MAX_C = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW    = $clog2(MAX_C + 1);

    logic          level_q;
    logic          repeating;
    logic [CW-1:0] cnt;

    assign rise = level & ~level_q;
    assign held = level;

    // First step on the edge, then one after the hold delay, then one per repeat period
    always_comb begin
        step = 1'b0;
        if (!inhibit && level) begin
            if (rise)
                step = 1'b1;
            else if (!repeating && cnt == CW'(HOLD_CYCLES))
                step = 1'b1;
            else if (repeating && cnt == CW'(REPEAT_CYCLES))
                step = 1'b1;
        end
    end

    // Edge register and cycles-since-last-step counter; both buttons down parks the counter at 0
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q   <= 1'b0;
            repeating <= 1'b0;
            cnt       <= '0;
        end else begin
            level_q <= level;
            if (inhibit || !level) begin
                cnt       <= '0;
                repeating <= 1'b0;
            end else if (rise) begin
                cnt <= CW'(1);
            end else if (step) begin
                cnt       <= CW'(1);
                repeating <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/time_adjust_unit.sv
// rtl/time_adjust_unit.sv - snapshot, field-by-field BCD edit and commit of the clock time
module time_adjust_unit
    import time_pkg::*;
#(
    parameter int FIELDS         = 3,
    parameter int HOLD_CYCLES    = 25000000,
    parameter int REPEAT_CYCLES  = 5000000,
    parameter int BLINK_CYCLES   = 12500000,
    parameter int TIMEOUT_CYCLES = 500000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PAIR_W*FIELDS-1:0] time_in,
    input  logic                     btn_mode,
    input  logic                     btn_up,
    input  logic                     btn_down,
    input  logic                     mode_12h,
    output logic [PAIR_W*FIELDS-1:0] time_out,
    output logic                     editing,
    output logic [FIELDS-1:0]        field_sel,
    output logic                     blink,
    output logic                     commit
);

    localparam int CUR_W = $clog2(FIELDS);
    localparam int BLK_W = $clog2(BLINK_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    adj_state_t                 state;
    logic [PAIR_W*FIELDS-1:0]   shadow;
    logic [CUR_W-1:0]           cursor;
    logic                       mode_q;
    logic [BLK_W-1:0]           blink_cnt;
    logic [TO_W-1:0]            to_cnt;
    logic                       both;
    logic                       mode_rise;
    logic                       activity;
    logic                       up_rise, up_step, up_held;
    logic                       dn_rise, dn_step, dn_held;
    logic [PAIR_W-1:0]          cur_pair;
    logic [PAIR_W-1:0]          new_pair;

    // One BCD step of a pair; out-of-range or non-BCD values snap to the range end
    function automatic logic [7:0] bcd_step(input logic [7:0] pair, input logic dir_up,
                                            input logic is_hour, input logic m12);
        logic [7:0] lo;
        logic [7:0] hi;
        logic [7:0] r;
        logic       ok;
        if (!is_hour) begin
            lo = 8'h00;
            hi = MIN_SEC_MAX;
        end else if (m12) begin
            lo = HOUR12_MIN;
            hi = HOUR12_MAX;
        end else begin
            lo = 8'h00;
            hi = HOUR24_MAX;
        end
        ok = (pair[3:0] <= 4'd9) && (pair[7:4] <= 4'd9) && (pair >= lo) && (pair <= hi);
        if (!ok)
            r = dir_up ? lo : hi;
        else if (dir_up)
            r = (pair == hi) ? lo :
                (pair[3:0] == 4'd9) ? {pair[7:4] + 4'd1, 4'd0} : pair + 8'd1;
        else
            r = (pair == lo) ? hi :
                (pair[3:0] == 4'd0) ? {pair[7:4] - 4'd1, 4'd9} : pair - 8'd1;
        return r;
    endfunction

    assign both      = btn_up & btn_down;
    assign mode_rise = btn_mode & ~mode_q;
    assign activity  = mode_rise | up_rise | dn_rise | up_step | dn_step;
    assign time_out  = shadow;

    btn_repeat #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_up (
        .clk     (clk),
        .rst     (rst),
        .level   (btn_up),
        .inhibit (both),
        .rise    (up_rise),
        .step    (up_step),
        .held    (up_held)
    );

    btn_repeat #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_down (
        .clk     (clk),
        .rst     (rst),
        .level   (btn_down),
        .inhibit (both),
        .rise    (dn_rise),
        .step    (dn_step),
        .held    (dn_held)
    );

    // Next value of the pair under the cursor; only the up/down choice matters when a step fires
    always_comb begin
        cur_pair = shadow[PAIR_W*cursor +: PAIR_W];
        new_pair = bcd_step(cur_pair, up_step, cursor == CUR_W'(FIELDS - 1), mode_12h);
    end

    // Edit FSM: shadow tracking, cursor walk, stepping, blink, timeout and commit pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            shadow    <= '0;
            cursor    <= '0;
            mode_q    <= 1'b0;
            editing   <= 1'b0;
            field_sel <= '0;
            blink     <= 1'b0;
            blink_cnt <= '0;
            to_cnt    <= '0;
            commit    <= 1'b0;
        end else begin
            mode_q <= btn_mode;
            commit <= 1'b0;
            case (state)
                ST_IDLE: begin
                    shadow <= time_in;
                    if (mode_rise) begin
                        state     <= ST_EDIT;
                        cursor    <= CUR_W'(FIELDS - 1);
                        editing   <= 1'b1;
                        field_sel <= FIELDS'(1) << (FIELDS - 1);
                        blink     <= 1'b0;
                        blink_cnt <= '0;
                        to_cnt    <= '0;
                    end
                end
                default: begin
                    if (up_step || dn_step)
                        shadow[PAIR_W*cursor +: PAIR_W] <= new_pair;
                    if (up_held || dn_held) begin
                        blink     <= 1'b0;
                        blink_cnt <= '0;
                    end else if (blink_cnt == BLK_W'(BLINK_CYCLES - 1)) begin
                        blink     <= ~blink;
                        blink_cnt <= '0;
                    end else begin
                        blink_cnt <= blink_cnt + BLK_W'(1);
                    end
                    to_cnt <= activity ? '0 : to_cnt + TO_W'(1);
                    if (mode_rise) begin
                        if (cursor == '0) begin
                            commit    <= 1'b1;
                            state     <= ST_IDLE;
                            editing   <= 1'b0;
                            field_sel <= '0;
                            blink     <= 1'b0;
                        end else begin
                            cursor    <= cursor - CUR_W'(1);
                            field_sel <= field_sel >> 1;
                        end
                    end else if (!activity && to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state     <= ST_IDLE;
                        editing   <= 1'b0;
                        field_sel <= '0;
                        blink     <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_adjust_unit.sv
// tb/tb_time_adjust_unit.sv - self-checking bench for time_adjust_unit
module tb_time_adjust_unit;

    localparam int FIELDS = 3;
    localparam int HOLD   = 6;
    localparam int REP    = 4;
    localparam int BLINK  = 5;
    localparam int TMO    = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] time_in;
    logic        btn_mode, btn_up, btn_down, mode_12h;
    logic [23:0] time_out;
    logic        editing;
    logic [2:0]  field_sel;
    logic        blink;
    logic        commit;

    always #5 clk = ~clk;

    time_adjust_unit #(
        .FIELDS         (FIELDS),
        .HOLD_CYCLES    (HOLD),
        .REPEAT_CYCLES  (REP),
        .BLINK_CYCLES   (BLINK),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .time_in   (time_in),
        .btn_mode  (btn_mode),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .mode_12h  (mode_12h),
        .time_out  (time_out),
        .editing   (editing),
        .field_sel (field_sel),
        .blink     (blink),
        .commit    (commit)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         fld;
        logic [7:0] val;
        bit         up;
        bit         m12;
        logic [7:0] exp;
    } vec_t;

    vec_t        vecs [16];
    logic [23:0] tin, texp;
    bit          seen;

    // reference model state
    bit         m_ed, m_commit;
    int         m_cur, m_idle, n_up, n_dn;
    bit         pm, pu, pd;
    logic [7:0] m_sh [FIELDS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_mode();
        btn_mode = 1'b1;
        tick();
        btn_mode = 1'b0;
        tick();
    endtask

    function automatic logic [7:0] ref_step(input logic [7:0] p, input bit up, input bit hour, input bit m12);
        int tens, ones, v, lo, hi;
        tens = int'(p[7:4]);
        ones = int'(p[3:0]);
        lo   = (hour && m12) ? 1 : 0;
        hi   = !hour ? 59 : (m12 ? 12 : 23);
        v    = tens * 10 + ones;
        if (tens > 9 || ones > 9 || v < lo || v > hi) v = up ? lo : hi;
        else if (up) v = (v == hi) ? lo : v + 1;
        else v = (v == lo) ? hi : v - 1;
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic bit rep_due(input int n, input bit r);
        return (n == 1 && r) || (n == HOLD + 1) || (n > HOLD + 1 && (n - HOLD - 1) % REP == 0);
    endfunction

    task automatic model_step();
        bit mr, ur, dr, us, ds, inh, act;
        mr  = btn_mode && !pm;
        ur  = btn_up && !pu;
        dr  = btn_down && !pd;
        inh = btn_up && btn_down;
        if (inh) begin
            n_up = 0;
            n_dn = 0;
        end else begin
            n_up = btn_up ? n_up + 1 : 0;
            n_dn = btn_down ? n_dn + 1 : 0;
        end
        us = !inh && btn_up && rep_due(n_up, ur);
        ds = !inh && btn_down && rep_due(n_dn, dr);
        pm = btn_mode;
        pu = btn_up;
        pd = btn_down;
        m_commit = 1'b0;
        if (!m_ed) begin
            for (int k = 0; k < FIELDS; k++) m_sh[k] = time_in[8*k +: 8];
            if (mr) begin
                m_ed   = 1'b1;
                m_cur  = FIELDS - 1;
                m_idle = 0;
            end
        end else begin
            if (us) m_sh[m_cur] = ref_step(m_sh[m_cur], 1'b1, m_cur == FIELDS - 1, mode_12h);
            if (ds) m_sh[m_cur] = ref_step(m_sh[m_cur], 1'b0, m_cur == FIELDS - 1, mode_12h);
            act = mr || ur || dr || us || ds;
            m_idle = act ? 0 : m_idle + 1;
            if (mr) begin
                if (m_cur == 0) begin
                    m_commit = 1'b1;
                    m_ed     = 1'b0;
                end else begin
                    m_cur--;
                end
            end else if (m_idle == TMO) begin
                m_ed = 1'b0;
            end
        end
    endtask

    initial begin
        vecs[0]  = '{2, 8'h23, 1'b1, 1'b0, 8'h00};
        vecs[1]  = '{2, 8'h00, 1'b0, 1'b0, 8'h23};
        vecs[2]  = '{2, 8'h12, 1'b1, 1'b1, 8'h01};
        vecs[3]  = '{2, 8'h01, 1'b0, 1'b1, 8'h12};
        vecs[4]  = '{2, 8'h00, 1'b1, 1'b1, 8'h01};
        vecs[5]  = '{2, 8'h15, 1'b0, 1'b1, 8'h12};
        vecs[6]  = '{2, 8'h09, 1'b1, 1'b0, 8'h10};
        vecs[7]  = '{2, 8'h2A, 1'b1, 1'b0, 8'h00};
        vecs[8]  = '{1, 8'h09, 1'b1, 1'b0, 8'h10};
        vecs[9]  = '{1, 8'h00, 1'b0, 1'b0, 8'h59};
        vecs[10] = '{1, 8'h7A, 1'b1, 1'b0, 8'h00};
        vecs[11] = '{1, 8'h10, 1'b0, 1'b0, 8'h09};
        vecs[12] = '{1, 8'h59, 1'b1, 1'b1, 8'h00};
        vecs[13] = '{1, 8'h65, 1'b0, 1'b0, 8'h59};
        vecs[14] = '{0, 8'h58, 1'b1, 1'b0, 8'h59};
        vecs[15] = '{0, 8'h3F, 1'b0, 1'b0, 8'h59};

        rst = 1'b1; time_in = 24'h123456;
        btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0; mode_12h = 1'b0;
        tick(); tick();
        check("rst_time_out", 32'(time_out), 32'h0);
        check("rst_editing", 32'(editing), 32'h0);
        check("rst_field_sel", 32'(field_sel), 32'h0);
        check("rst_blink", 32'(blink), 32'h0);
        check("rst_commit", 32'(commit), 32'h0);

        // snapshot freeze
        rst = 1'b0; time_in = 24'h235958;
        tick(); tick();
        btn_mode = 1'b1; tick();
        check("enter_editing", 32'(editing), 32'h1);
        check("enter_field_sel", 32'(field_sel), 32'h4);
        btn_mode = 1'b0; time_in = 24'h000102;
        tick(); tick();
        check("frozen", 32'(time_out), 32'h235958);

        // hours wrap in 24h
        btn_up = 1'b1; tick(); btn_up = 1'b0; tick();
        check("hr23_up", 32'(time_out), 32'h005958);
        btn_down = 1'b1; tick(); btn_down = 1'b0; tick();
        check("hr00_down", 32'(time_out), 32'h235958);

        // blink toggles while idle in edit, forced low and auto-repeat while held
        seen = 1'b0;
        for (int k = 0; k < 2*BLINK + 2 && !seen; k++) begin
            tick();
            if (blink) seen = 1'b1;
        end
        check("blink_toggles", 32'(seen), 32'h1);
        btn_up = 1'b1;
        for (int k = 0; k < HOLD + 2*REP; k++) begin
            tick();
            if (k == 2) check("blink_held", 32'(blink), 32'h0);
        end
        btn_up = 1'b0; tick();
        check("hold_repeat", 32'(time_out), 32'h025958);

        // cursor walk and commit
        btn_mode = 1'b1; tick();
        check("sel_min", 32'(field_sel), 32'h2);
        btn_mode = 1'b0; tick();
        btn_mode = 1'b1; tick();
        check("sel_sec", 32'(field_sel), 32'h1);
        btn_mode = 1'b0; tick();
        btn_mode = 1'b1; tick();
        check("commit_pulse", 32'({commit, editing}), 32'h2);
        check("commit_value", 32'(time_out), 32'h025958);
        btn_mode = 1'b0; tick();
        check("commit_one_cycle", 32'(commit), 32'h0);
        tick();
        check("track_resumes", 32'(time_out), 32'h000102);

        // timeout without commit
        pulse_mode();
        seen = 1'b0;
        for (int k = 0; k < TMO + 3; k++) begin
            tick();
            if (commit) seen = 1'b1;
            if (k == TMO - 5) check("still_editing", 32'(editing), 32'h1);
        end
        check("timeout_exit", 32'(editing), 32'h0);
        check("timeout_no_commit", 32'(seen), 32'h0);

        // both buttons together: no step
        time_in = 24'h105030; tick(); tick();
        pulse_mode();
        btn_up = 1'b1; btn_down = 1'b1;
        tick(); tick(); tick();
        btn_up = 1'b0; btn_down = 1'b0; tick();
        check("both_no_step", 32'(time_out), 32'h105030);

        // reset mid-edit
        btn_up = 1'b1; tick(); btn_up = 1'b0;
        rst = 1'b1; tick();
        check("rst_mid_edit", 32'({time_out, editing, field_sel, blink, commit}), 32'h0);
        rst = 1'b0;

        // table-driven field arithmetic
        for (int i = 0; i < 16; i++) begin
            tin  = 24'h114733;
            texp = 24'h114733;
            tin[8*vecs[i].fld +: 8]  = vecs[i].val;
            texp[8*vecs[i].fld +: 8] = vecs[i].exp;
            rst = 1'b1; tick(); rst = 1'b0;
            time_in  = tin;
            mode_12h = vecs[i].m12;
            tick();
            pulse_mode();
            for (int k = 0; k < 2 - vecs[i].fld; k++) pulse_mode();
            if (vecs[i].up) btn_up = 1'b1;
            else btn_down = 1'b1;
            tick();
            btn_up = 1'b0; btn_down = 1'b0;
            tick();
            check($sformatf("vec%0d", i), 32'(time_out), 32'(texp));
        end

        // randomized run against the reference model
        rst = 1'b1; mode_12h = 1'b0; tick(); rst = 1'b0;
        m_ed = 1'b0; m_commit = 1'b0; m_cur = 0; m_idle = 0;
        n_up = 0; n_dn = 0; pm = 1'b0; pu = 1'b0; pd = 1'b0;
        for (int k = 0; k < FIELDS; k++) m_sh[k] = 8'h00;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 3) == 0) time_in = 24'($urandom);
            btn_mode = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 4) == 0) btn_up = ~btn_up;
            if ($urandom_range(0, 4) == 0) btn_down = ~btn_down;
            if ($urandom_range(0, 60) == 0) mode_12h = ~mode_12h;
            model_step();
            tick();
            check($sformatf("rand%0d", cyc),
                  32'({time_out, editing, field_sel, commit}),
                  32'({m_sh[2], m_sh[1], m_sh[0], m_ed,
                       (m_ed ? 3'(1 << m_cur) : 3'b000), m_commit}));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
